irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl_pkg.sv | 20 ++
 rtl/irq_ctrl_sync_edge.sv | 31 +++
 rtl/irq_ctrl.sv | 126 ++++++++++++
 tb/tb_irq_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, STATUS layout
// and the request/service state encoding.
package irq_ctrl_pkg;

  localparam logic [1:0] ADDR_PEND  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_STAT  = 2'd2;
  localparam logic [1:0] ADDR_SWSET = 2'd3;

  localparam int STAT_ID_LSB    = 0;
  localparam int STAT_REQ_BIT   = 3;
  localparam int STAT_INSVC_BIT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_ctrl_sync_edge.sv
// Single-bit synchroniser plus rising-edge detector for one interrupt source.
// Edges are suppressed until the history flop holds a real post-reset sample.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   arm_q;
  logic                   hist_q;

  // arm_q keeps a level held high across reset from looking like an edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      arm_q  <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q & arm_q[SYNC_STAGES];

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches source edges as pending, masks,
// priority-encodes (index 0 highest) and hands one request at a time to the CPU.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             int_req,
  output logic [2:0]       int_id,
  input  logic             int_ack,
  output logic             in_service
);

  logic [N_SRC-1:0] rise, pend_q, pend_d, mask_q, mask_d, elig;
  logic [N_SRC-1:0] w1c, w1s, ack_clr, id_onehot;
  logic [2:0]       winner, int_id_q;
  logic             int_req_q, in_service_q;
  logic             wr_pend, wr_mask, wr_stat, wr_swset, ack, eoi;
  logic             unused_wdata;
  irq_state_e       state_q;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (clk),
      .rst_i  (rst),
      .d_i    (src[g]),
      .rise_o (rise[g])
    );
  end

  assign unused_wdata = ^reg_wdata[31:N_SRC];

  always_comb begin
    wr_pend  = reg_we && (reg_addr == ADDR_PEND);
    wr_mask  = reg_we && (reg_addr == ADDR_MASK);
    wr_stat  = reg_we && (reg_addr == ADDR_STAT);
    wr_swset = reg_we && (reg_addr == ADDR_SWSET);
    ack      = int_ack && (state_q == REQ);
    eoi      = wr_stat && (state_q == SERVICE);
    w1c      = wr_pend  ? reg_wdata[N_SRC-1:0] : '0;
    w1s      = wr_swset ? reg_wdata[N_SRC-1:0] : '0;
    for (int i = 0; i < N_SRC; i++) id_onehot[i] = (int_id_q == 3'(i));
    ack_clr  = ack ? id_onehot : '0;
    // sets are OR-ed in last so they win over any clear of the same bit
    pend_d   = (pend_q & ~w1c & ~ack_clr) | rise | w1s;
    mask_d   = wr_mask ? reg_wdata[N_SRC-1:0] : mask_q;
    elig     = pend_q & mask_q;
    winner   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) winner = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      int_req_q    <= 1'b0;
      int_id_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|elig) begin
            int_id_q  <= winner;
            int_req_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (ack) begin
            int_req_q    <= 1'b0;
            in_service_q <= 1'b1;
            state_q      <= SERVICE;
          end else if (~|(pend_d & mask_d & id_onehot)) begin
            int_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            in_service_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_PEND: reg_rdata[N_SRC-1:0] = pend_q;
      ADDR_MASK: reg_rdata[N_SRC-1:0] = mask_q;
      ADDR_STAT: begin
        reg_rdata[STAT_ID_LSB +: 3]  = int_id_q;
        reg_rdata[STAT_REQ_BIT]      = int_req_q;
        reg_rdata[STAT_INSVC_BIT]    = in_service_q;
      end
      default: reg_rdata = '0;
    endcase
  end

  assign int_req    = int_req_q;
  assign int_id     = int_id_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: latency, priority, masking, W1C/W1S, EOI and reset.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        int_req;
  logic [2:0]  int_id;
  logic        int_ack;
  logic        in_service;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_val;

  irq_ctrl #(.N_SRC(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .src        (src),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .int_req    (int_req),
    .int_id     (int_id),
    .int_ack    (int_ack),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    tick();
    reg_we    = 1'b0;
    reg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({int_req, int_id, in_service} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=00000", {int_req, int_id, in_service});
    end
    rd(2'd0, rd_val);
    checks++;
    if (rd_val !== 32'h0) begin errors++; $display("FAIL reset_pend got=%h exp=0", rd_val); end
    rd(2'd1, rd_val);
    checks++;
    if (rd_val !== 32'h0) begin errors++; $display("FAIL reset_mask got=%h exp=0", rd_val); end
  endtask

  task automatic test_basic();
    wr(2'd1, 32'h01);
    src[0] = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (int_req !== 1'b0) begin errors++; $display("FAIL t1_req_early got=%b exp=0", int_req); end
    rd(2'd0, rd_val);
    checks++;
    if (rd_val !== 32'h01) begin errors++; $display("FAIL t1_pend got=%h exp=01", rd_val); end
    tick();
    checks++;
    if (int_req !== 1'b1 || int_id !== 3'd0) begin
      errors++; $display("FAIL t1_req got=%b/%0d exp=1/0", int_req, int_id);
    end
    src[0] = 1'b0;
    ack_pulse();
    checks++;
    if (int_req !== 1'b0 || in_service !== 1'b1) begin
      errors++; $display("FAIL t1_ack got=%b/%b exp=0/1", int_req, in_service);
    end
    rd(2'd0, rd_val);
    checks++;
    if (rd_val !== 32'h0) begin errors++; $display("FAIL t1_pend_ack got=%h exp=0", rd_val); end
    rd(2'd2, rd_val);
    checks++;
    if (rd_val !== 32'h10) begin errors++; $display("FAIL t1_status got=%h exp=10", rd_val); end
    wr(2'd2, 32'h0);
    tick(); tick();
    rd(2'd2, rd_val);
    checks++;
    if (rd_val !== 32'h0 || in_service !== 1'b0) begin
      errors++; $display("FAIL t1_eoi got=%h exp=0", rd_val);
    end
  endtask

  task automatic test_priority();
    wr(2'd1, 32'hFF);
    src[5] = 1'b1;
    src[2] = 1'b1;
    tick(); tick(); tick(); tick();
    checks++;
    if (int_req !== 1'b1 || int_id !== 3'd2) begin
      errors++; $display("FAIL t2_first got=%b/%0d exp=1/2", int_req, int_id);
    end
    src[5] = 1'b0;
    src[2] = 1'b0;
    ack_pulse();
    rd(2'd0, rd_val);
    checks++;
    if (rd_val !== 32'h20) begin errors++; $display("FAIL t2_pend_mid got=%h exp=20", rd_val); end
    wr(2'd2, 32'h0);
    tick();
    checks++;
    if (int_req !== 1'b1 || int_id !== 3'd5 || in_service !== 1'b0) begin
      errors++; $display("FAIL t2_second got=%b/%0d/%b exp=1/5/0", int_req, int_id, in_service);
    end
    ack_pulse();
    wr(2'd2, 32'h0);
    tick(); tick();
    rd(2'd0, rd_val);
    checks++;
    if (int_req !== 1'b0 || in_service !== 1'b0 || rd_val !== 32'h0) begin
      errors++; $display("FAIL t2_idle got=%b/%b/%h exp=0/0/0", int_req, in_service, rd_val);
    end
  endtask

  task automatic test_mask();
    wr(2'd1, 32'h00);
    src[3] = 1'b1;
    tick(); tick(); tick(); tick();
    rd(2'd0, rd_val);
    checks++;
    if (rd_val !== 32'h08 || int_req !== 1'b0) begin
      errors++; $display("FAIL t3_masked got=%h/%b exp=08/0", rd_val, int_req);
    end
    src[3] = 1'b0;
    wr(2'd1, 32'h08);
    checks++;
    if (int_req !== 1'b0) begin errors++; $display("FAIL t3_req_early got=%b exp=0", int_req); end
    tick();
    checks++;
    if (int_req !== 1'b1 || int_id !== 3'd3) begin
      errors++; $display("FAIL t3_unmask got=%b/%0d exp=1/3", int_req, int_id);
    end
    ack_pulse();
    wr(2'd2, 32'h0);
    tick();
  endtask

  task automatic test_w1c();
    wr(2'd1, 32'h02);
    wr(2'd3, 32'h02);
    tick();
    checks++;
    if (int_req !== 1'b1 || int_id !== 3'd1) begin
      errors++; $display("FAIL t4_req got=%b/%0d exp=1/1", int_req, int_id);
    end
    wr(2'd0, 32'h02);
    checks++;
    if (int_req !== 1'b0) begin errors++; $display("FAIL t4_withdraw got=%b exp=0", int_req); end
    tick(); tick();
    rd(2'd0, rd_val);
    checks++;
    if (int_req !== 1'b0 || in_service !== 1'b0 || rd_val !== 32'h0) begin
      errors++; $display("FAIL t4_idle got=%b/%b/%h exp=0/0/0", int_req, in_service, rd_val);
    end
    // rise[4] is live in the cycle before the third edge after src[4] goes high
    src[4] = 1'b1;
    tick(); tick();
    wr(2'd0, 32'h10);
    rd(2'd0, rd_val);
    checks++;
    if (rd_val !== 32'h10) begin errors++; $display("FAIL t4_set_wins got=%h exp=10", rd_val); end
    wr(2'd0, 32'h10);
    rd(2'd0, rd_val);
    checks++;
    if (rd_val !== 32'h0) begin errors++; $display("FAIL t4_w1c got=%h exp=0", rd_val); end
    src[4] = 1'b0;
    tick();
  endtask

  task automatic test_swset_reset();
    wr(2'd1, 32'h80);
    wr(2'd3, 32'h80);
    tick();
    checks++;
    if (int_req !== 1'b1 || int_id !== 3'd7) begin
      errors++; $display("FAIL t5_req got=%b/%0d exp=1/7", int_req, int_id);
    end
    rd(2'd3, rd_val);
    checks++;
    if (rd_val !== 32'h0) begin errors++; $display("FAIL t5_swset_rd got=%h exp=0", rd_val); end
    src[6] = 1'b1;
    ack_pulse();
    tick(); tick(); tick();
    checks++;
    if (in_service !== 1'b1) begin errors++; $display("FAIL t5_service got=%b exp=1", in_service); end
    rst = 1'b1;
    #1;
    rd(2'd0, rd_val);
    checks++;
    if ({int_req, int_id, in_service} !== 5'b0 || rd_val !== 32'h0) begin
      errors++; $display("FAIL t5_async_rst got=%b/%h exp=00000/0", {int_req, int_id, in_service}, rd_val);
    end
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    wr(2'd1, 32'hFF);
    tick(); tick(); tick();
    rd(2'd0, rd_val);
    checks++;
    if (rd_val !== 32'h0 || int_req !== 1'b0) begin
      errors++; $display("FAIL t5_held_src got=%h/%b exp=0/0", rd_val, int_req);
    end
    ack_pulse();
    checks++;
    if (in_service !== 1'b0 || int_req !== 1'b0) begin
      errors++; $display("FAIL t5_idle_ack got=%b/%b exp=0/0", in_service, int_req);
    end
    wr(2'd2, 32'h0);
    tick();
    checks++;
    if (in_service !== 1'b0 || int_req !== 1'b0) begin
      errors++; $display("FAIL t5_idle_eoi got=%b/%b exp=0/0", in_service, int_req);
    end
    wr(2'd3, 32'h01);
    tick();
    checks++;
    if (int_req !== 1'b1 || int_id !== 3'd0) begin
      errors++; $display("FAIL t5_after_rst got=%b/%0d exp=1/0", int_req, int_id);
    end
    src[6] = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    src       = '0;
    reg_we    = 1'b0;
    reg_addr  = 2'd0;
    reg_wdata = '0;
    int_ack   = 1'b0;
    tick();
    test_reset();
    tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    test_basic();
    test_priority();
    test_mask();
    test_w1c();
    test_swset_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
